// File: rtl/cim_pkg.sv
// Shared widths and arithmetic helpers for the CIM macro datapath and its downstream stages.
// The default partial-sum width follows the stage-1/3/4 growth of the 8x8 macro configuration.
package cim_pkg;

   localparam int CIM_ACT_BITS   = 8;
   localparam int CIM_WGT_BITS   = 8;
   localparam int CIM_ROWS       = 8;
   localparam int CIM_BIT_SLICES = 8;

   // Stage 1 is the product, stage 3 the row adder tree, stage 4 the bit-slice shift-add.
   localparam int CIM_STAGE1_WIDTH = CIM_ACT_BITS + CIM_WGT_BITS;
   localparam int CIM_STAGE3_WIDTH = CIM_STAGE1_WIDTH + $clog2(CIM_ROWS);
   localparam int CIM_STAGE4_WIDTH = CIM_STAGE3_WIDTH + $clog2(CIM_BIT_SLICES);

   localparam int CIM_IN_WIDTH    = CIM_STAGE4_WIDTH;
   localparam int CIM_ACC_WIDTH   = 32;
   localparam int CIM_NUM_PSUMS   = 4;
   localparam int CIM_OUT_WIDTH   = 8;
   localparam int CIM_SHIFT_WIDTH = 5;
   localparam int CIM_FIFO_DEPTH  = 4;

   localparam int CIM_CALC_WIDTH = 64;
   typedef logic signed [CIM_CALC_WIDTH-1:0] cim_calc_t;

   function automatic cim_calc_t round_shift(input cim_calc_t v, input logic [7:0] sh);
      cim_calc_t bias;
      if (sh == 8'd0) return v;
      bias = cim_calc_t'(1) <<< (sh - 8'd1);
      return (v + bias) >>> sh;
   endfunction

   function automatic cim_calc_t sat_signed(input cim_calc_t v, input int unsigned width);
      cim_calc_t hi;
      cim_calc_t lo;
      hi = (cim_calc_t'(1) <<< (width - 1)) - cim_calc_t'(1);
      lo = -hi - cim_calc_t'(1);
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

// File: rtl/cim_sync_fifo.sv
// Small synchronous FIFO with a registered storage head; data at the head stays put until popped.
module cim_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           pop_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push & (~full | pop);
   assign do_pop   = pop & (~empty | push);
   assign pop_data = mem[rd_ptr];

   function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= next_ptr(wr_ptr);
         end
         if (do_pop) rd_ptr <= next_ptr(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/cim_psum_requant.sv
// Accumulates NUM_PSUMS signed partial sums per activation, requantizes (ReLU, rounding shift,
// saturation) and queues the results behind a valid/ready output.
module cim_psum_requant
   import cim_pkg::*;
#(
   parameter int IN_WIDTH    = CIM_IN_WIDTH,
   parameter int ACC_WIDTH   = CIM_ACC_WIDTH,
   parameter int NUM_PSUMS   = CIM_NUM_PSUMS,
   parameter int OUT_WIDTH   = CIM_OUT_WIDTH,
   parameter int SHIFT_WIDTH = CIM_SHIFT_WIDTH,
   parameter int FIFO_DEPTH  = CIM_FIFO_DEPTH
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic signed [IN_WIDTH-1:0]  in_data,
   input  logic [SHIFT_WIDTH-1:0]      shift_amt,
   input  logic                        relu_en,
   input  logic                        clear,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic signed [OUT_WIDTH-1:0] out_data,
   output logic                        group_busy,
   output logic                        acc_ovf
);

   localparam int CNT_W  = (NUM_PSUMS > 1) ? $clog2(NUM_PSUMS) : 1;
   localparam int CNT_FW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PSUMS - 1);

   logic [CNT_W-1:0]               psum_cnt;
   logic signed [ACC_WIDTH-1:0]    acc;
   logic signed [ACC_WIDTH-1:0]    beat_ext;
   logic signed [ACC_WIDTH-1:0]    acc_sum;
   logic signed [ACC_WIDTH-1:0]    grp_sum;
   logic [SHIFT_WIDTH-1:0]         sh_q;
   logic [SHIFT_WIDTH-1:0]         grp_sh;
   logic                           relu_q;
   logic                           grp_relu;
   logic signed [ACC_WIDTH-1:0]    sum_q;
   logic [SHIFT_WIDTH-1:0]         sum_sh;
   logic                           sum_relu;
   logic                           sum_vld;
   logic                           beat;
   logic                           first_beat;
   logic                           last_beat;
   logic                           add_ovf;
   logic [CNT_FW-1:0]              fifo_count;
   logic [CNT_FW:0]                occupancy;
   logic                           fifo_full;
   logic                           fifo_empty;
   logic signed [OUT_WIDTH-1:0]    req_data;
   cim_calc_t                      relu_v;
   cim_calc_t                      shifted;
   cim_calc_t                      sat_v;

   assign beat_ext   = ACC_WIDTH'(in_data);
   assign first_beat = (psum_cnt == '0);
   assign last_beat  = (psum_cnt == LAST_CNT);
   assign acc_sum    = acc + beat_ext;
   assign grp_sum    = first_beat ? beat_ext : acc_sum;
   assign grp_sh     = first_beat ? shift_amt : sh_q;
   assign grp_relu   = first_beat ? relu_en : relu_q;
   assign add_ovf    = ~first_beat & (acc[ACC_WIDTH-1] == beat_ext[ACC_WIDTH-1])
                       & (acc_sum[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);

   // A result still in the requant register already owns a FIFO slot, so count it as occupied.
   assign occupancy  = {1'b0, fifo_count} + {{CNT_FW{1'b0}}, sum_vld};
   assign in_ready   = reset & ~fifo_full & (occupancy < (CNT_FW + 1)'(FIFO_DEPTH));
   assign beat       = in_valid & in_ready & ~clear;
   assign group_busy = (psum_cnt != '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         psum_cnt <= '0;
         acc      <= '0;
         sh_q     <= '0;
         relu_q   <= 1'b0;
      end else if (clear) begin
         psum_cnt <= '0;
         acc      <= '0;
      end else if (beat) begin
         acc      <= grp_sum;
         psum_cnt <= last_beat ? '0 : psum_cnt + 1'b1;
         if (first_beat) begin
            sh_q   <= shift_amt;
            relu_q <= relu_en;
         end
      end
   end

   // The group's config travels with its sum so the next group can start on the same edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sum_vld  <= 1'b0;
         sum_q    <= '0;
         sum_sh   <= '0;
         sum_relu <= 1'b0;
      end else begin
         sum_vld <= beat & last_beat;
         if (beat & last_beat) begin
            sum_q    <= grp_sum;
            sum_sh   <= grp_sh;
            sum_relu <= grp_relu;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) acc_ovf <= 1'b0;
      else if (beat & add_ovf) acc_ovf <= 1'b1;
   end

   always_comb begin
      relu_v = cim_calc_t'(sum_q);
      if (sum_relu && sum_q[ACC_WIDTH-1]) relu_v = '0;
      shifted  = round_shift(relu_v, 8'(sum_sh));
      sat_v    = sat_signed(shifted, OUT_WIDTH);
      req_data = OUT_WIDTH'(sat_v);
   end

   assign out_valid = ~fifo_empty;

   cim_sync_fifo #(
      .WIDTH (OUT_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_out_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (sum_vld),
      .push_data (req_data),
      .pop       (out_valid & out_ready),
      .pop_data  (out_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

endmodule

// File: tb/tb_cim_psum_requant.sv
// Scoreboard bench for cim_psum_requant: a default instance for datapath/flow control and a
// narrow-accumulator instance for the overflow flag.
module tb_cim_psum_requant;

   localparam int IN_W  = 22;
   localparam int OUT_W = 8;
   localparam int SH_W  = 5;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic                     in_valid, in_ready, relu_en, clear, out_valid, out_ready;
   logic signed [IN_W-1:0]   in_data;
   logic [SH_W-1:0]          shift_amt;
   logic signed [OUT_W-1:0]  out_data;
   logic                     group_busy, acc_ovf;

   logic                     ov_in_valid, ov_in_ready, ov_out_valid, ov_group_busy, ov_acc_ovf;
   logic signed [IN_W-1:0]   ov_in_data;
   logic signed [OUT_W-1:0]  ov_out_data;

   cim_psum_requant dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .shift_amt(shift_amt), .relu_en(relu_en), .clear(clear), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .group_busy(group_busy), .acc_ovf(acc_ovf)
   );

   cim_psum_requant #(.ACC_WIDTH(24), .NUM_PSUMS(8)) dut_ovf (
      .clk(clk), .reset(reset), .in_valid(ov_in_valid), .in_ready(ov_in_ready),
      .in_data(ov_in_data), .shift_amt(5'd0), .relu_en(1'b0), .clear(1'b0),
      .out_valid(ov_out_valid), .out_ready(1'b1), .out_data(ov_out_data),
      .group_busy(ov_group_busy), .acc_ovf(ov_acc_ovf)
   );

   int     tests_run    = 0;
   int     tests_failed = 0;
   int     pop_count    = 0;
   int     groups_done  = 0;
   longint sb_q[$];

   task automatic check_output(input string tag, input logic signed [63:0] obs,
                               input logic signed [63:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Reference requantizer built on real arithmetic rather than integer shifts.
   function automatic longint model_requant(input longint sum, input int sh, input bit relu);
      longint v;
      real    scale;
      real    r;
      v = sum;
      if (relu && v < 0) v = 0;
      scale = 1.0;
      for (int i = 0; i < sh; i++) scale = scale * 2.0;
      r = $floor(real'(v) / scale + 0.5);
      v = longint'($rtoi(r));
      if (v > 127)  v = 127;
      if (v < -128) v = -128;
      return v;
   endfunction

   always @(negedge clk) begin
      #1;
      if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         pop_count++;
         if (sb_q.size() == 0) check_output("sb_extra", 1, 0);
         else check_output("sb_data", out_data, sb_q.pop_front());
      end
   end

   // Called at a falling edge; returns at the falling edge after the beat is accepted.
   task automatic apply_stimulus(input longint d, input int sh, input bit relu);
      int waited = 0;
      in_valid  = 1'b1;
      in_data   = d[IN_W-1:0];
      shift_amt = sh[SH_W-1:0];
      relu_en   = relu;
      while (in_ready !== 1'b1 && waited < 300) begin
         @(negedge clk);
         waited++;
      end
      if (in_ready !== 1'b1) check_output("in_ready_timeout", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic send_group(input longint b0, input longint b1, input longint b2,
                             input longint b3, input int sh, input int sh_rest, input bit relu);
      sb_q.push_back(model_requant(b0 + b1 + b2 + b3, sh, relu));
      apply_stimulus(b0, sh, relu);
      apply_stimulus(b1, sh_rest, relu);
      apply_stimulus(b2, sh_rest, relu);
      apply_stimulus(b3, sh_rest, relu);
   endtask

   task automatic wait_drain(input string tag);
      int n = 0;
      while ((sb_q.size() != 0 || out_valid === 1'b1) && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (sb_q.size() != 0) check_output({tag, "_drain"}, sb_q.size(), 0);
      repeat (3) @(negedge clk);
   endtask

   task automatic ov_beat(input longint d);
      int waited = 0;
      ov_in_valid = 1'b1;
      ov_in_data  = d[IN_W-1:0];
      while (ov_in_ready !== 1'b1 && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      if (ov_in_ready !== 1'b1) check_output("ov_ready_timeout", ov_in_ready, 1);
      @(negedge clk);
      ov_in_valid = 1'b0;
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL global_timeout: simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      int n;
      int pops_before;
      reset = 1'b0; in_valid = 1'b0; in_data = '0; shift_amt = '0; relu_en = 1'b0;
      clear = 1'b0; out_ready = 1'b0; ov_in_valid = 1'b0; ov_in_data = '0;
      repeat (3) @(negedge clk);
      check_output("rst_in_ready", in_ready, 0);
      check_output("rst_out_valid", out_valid, 0);
      check_output("rst_out_data", out_data, 0);
      check_output("rst_group_busy", group_busy, 0);
      check_output("rst_acc_ovf", acc_ovf, 0);
      reset = 1'b1;
      #1;
      check_output("rel_in_ready", in_ready, 1);
      @(negedge clk);
      out_ready = 1'b1;

      // Basic group with exact output latency
      sb_q.push_back(model_requant(100, 2, 0));
      apply_stimulus(10, 2, 0);
      apply_stimulus(20, 2, 0);
      check_output("busy_mid", group_busy, 1);
      apply_stimulus(30, 2, 0);
      apply_stimulus(40, 2, 0);
      check_output("lat_t1", out_valid, 0);
      check_output("busy_done", group_busy, 0);
      @(negedge clk);
      check_output("lat_t2", out_valid, 1);
      wait_drain("basic");

      // Rounding, saturation, ReLU, back to back
      send_group(25, 25, 26, 26, 2, 2, 0);
      send_group(-26, -26, -25, -25, 2, 2, 0);
      send_group(250, 250, 250, 250, 0, 0, 0);
      send_group(-100, -100, -100, -100, 0, 0, 0);
      send_group(-100, -100, -100, -100, 0, 0, 1);
      send_group(-20, -10, -10, -10, 0, 0, 0);
      send_group(1000, 2000, -500, 7, 5, 5, 1);
      send_group(-3, 0, 0, 0, 1, 1, 0);
      wait_drain("datapath");

      // Shift changed mid-group must be ignored
      send_group(10, 20, 30, 40, 2, 0, 0);
      wait_drain("latch");

      // Clear aborts a partial group and drops its own beat
      apply_stimulus(5, 0, 0);
      apply_stimulus(5, 0, 0);
      clear = 1'b1; in_valid = 1'b1; in_data = 22'sd100;
      @(negedge clk);
      clear = 1'b0; in_valid = 1'b0;
      check_output("clear_busy", group_busy, 0);
      send_group(1, 1, 1, 1, 0, 0, 0);
      wait_drain("clear");

      // Backpressure: six groups against a stalled consumer
      out_ready   = 1'b0;
      groups_done = 0;
      fork
         begin
            for (int g = 0; g < 6; g++) begin
               send_group(1, 1, 1, 1, 0, 0, 0);
               groups_done++;
            end
         end
      join_none
      n = 0;
      while (in_ready === 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      repeat (10) @(negedge clk);
      check_output("bp_in_ready", in_ready, 0);
      check_output("bp_groups", groups_done, 4);
      check_output("bp_out_valid", out_valid, 1);
      check_output("bp_head", out_data, 4);
      pops_before = pop_count;
      out_ready = 1'b1;
      n = 0;
      while (groups_done < 6 && n < 400) begin
         @(negedge clk);
         n++;
      end
      check_output("bp_all_sent", groups_done, 6);
      wait_drain("bp");
      check_output("bp_pops", pop_count - pops_before, 6);

      // Overflow on the 24-bit accumulator instance
      check_output("ovf_init", ov_acc_ovf, 0);
      for (int i = 0; i < 8; i++) begin
         ov_beat(longint'(2097151));
         if (i == 3) check_output("ovf_4beats", ov_acc_ovf, 0);
         if (i == 4) check_output("ovf_set", ov_acc_ovf, 1);
      end
      for (int i = 0; i < 8; i++) ov_beat(1);
      check_output("ovf_sticky", ov_acc_ovf, 1);

      // Reset with two buffered results and a partial group
      out_ready = 1'b0;
      send_group(1, 2, 3, 4, 0, 0, 0);
      send_group(-1, -1, -1, -1, 0, 0, 0);
      repeat (4) @(negedge clk);
      check_output("rm_pre_valid", out_valid, 1);
      apply_stimulus(7, 0, 0);
      apply_stimulus(7, 0, 0);
      check_output("rm_pre_busy", group_busy, 1);
      reset = 1'b0;
      #1;
      check_output("rm_out_valid", out_valid, 0);
      check_output("rm_out_data", out_data, 0);
      check_output("rm_acc_ovf", ov_acc_ovf, 0);
      check_output("rm_group_busy", group_busy, 0);
      check_output("rm_in_ready", in_ready, 0);
      sb_q.delete();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      send_group(10, 20, 30, 40, 2, 2, 0);
      wait_drain("post_reset");
      repeat (5) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
